pin_loopback_checker: RTL

//   Self-checking stimulus/response engine for the pin-level inverter/pass-through tile.

---
 rtl/pin_loopback_checker_if.sv | 66 ++++++
 rtl/pin_loopback_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pin_loopback_checker_if.sv
// ----------------------------------------------------------------------------
// pin_loopback_checker_if
//   Bundles the control, pin-level and result signals of pin_loopback_checker.
//   The checker connects through the "slave" modport; whoever drives it
//   (tester logic, board glue or a testbench) uses the "master" modport.
//
//   Optional feature macro: CHECK_MASK_EN adds check_mask[7:0].
//
// Signal summary (direction as seen from the checker)
//   ena            in   1      1 = advance; 0 = freeze every piece of state
//   start          in   1      run request pulse, honoured in IDLE/DONE only
//   resp_in        in   8      tile uo_out
//   check_mask     in   8      (CHECK_MASK_EN only) 1 = compare that bit
//   stim_out       out  8      tile ui_in, registered
//   busy           out  1      run in progress (DRIVE/DRAIN)
//   done           out  1      sticky run-complete flag
//   pass           out  1      valid with done; 1 = no mismatches
//   err_count      out  ERR_W  saturating mismatch count
//   first_err_vec  out  8      stimulus of the first mismatch, 0 if none
//   dbg_state      out  2      FSM state: 0 IDLE, 1 DRIVE, 2 DRAIN, 3 DONE
//
// Control semantics: there is no valid/ready pair here. start is a request
// that is accepted on a rising edge where ena=1 and the checker is in IDLE or
// DONE; acceptance is visible as busy=1 after that edge. A start seen in any
// other state, or while ena=0, is dropped and never queued. ena=0 acts as a
// global stall: no state moves and resp_in is not sampled on that edge.
// ----------------------------------------------------------------------------
interface pin_loopback_checker_if #(
   parameter int ERR_W = 8
);
   logic             ena;
   logic             start;
   logic [7:0]       resp_in;
`ifdef CHECK_MASK_EN
   logic [7:0]       check_mask;
`endif
   logic [7:0]       stim_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [7:0]       first_err_vec;
   logic [1:0]       dbg_state;

`ifdef CHECK_MASK_EN
   modport master (
      output ena, start, resp_in, check_mask,
      input  stim_out, busy, done, pass, err_count, first_err_vec, dbg_state
   );

   modport slave (
      input  ena, start, resp_in, check_mask,
      output stim_out, busy, done, pass, err_count, first_err_vec, dbg_state
   );
`else
   modport master (
      output ena, start, resp_in,
      input  stim_out, busy, done, pass, err_count, first_err_vec, dbg_state
   );

   modport slave (
      input  ena, start, resp_in,
      output stim_out, busy, done, pass, err_count, first_err_vec, dbg_state
   );
`endif
endinterface

// File: rtl/pin_loopback_checker.sv
// ----------------------------------------------------------------------------
// pin_loopback_checker
//   Tester-side stimulus/response engine for the pin-level inverter /
//   pass-through tile. An 8-bit LFSR stream is launched on stim_out (the
//   tile's ui_in); resp_in (the tile's uo_out) is compared LAT edges later
//   against {stim[7:4], ~stim[3:0]}. The run reports pass/fail, a saturating
//   mismatch count and the stimulus of the first mismatching vector.
//
//   Optional feature macro: CHECK_MASK_EN. When defined, bus.check_mask
//   selects which bits are compared; the mask travels down the check pipe
//   with its vector. When undefined all eight bits are compared.
//
// Parameters
//   NUM_VEC    vectors per run (>=1)
//   LAT        edges from stimulus launch to response sample (>=1)
//   ERR_W      width of err_count (must match the interface ERR_W)
//   LFSR_SEED  first vector of every run; 0 is replaced by 8'h01
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        pin_loopback_checker_if.slave (see the interface header)
//
// FSM: IDLE -start-> DRIVE -NUM_VEC launches-> DRAIN -LAT edges-> DONE
//      DONE -start-> DRIVE. IDLE is left only by start, re-entered only by
//      reset. A run therefore keeps busy high for NUM_VEC+LAT edges.
// ----------------------------------------------------------------------------
module pin_loopback_checker #(
   parameter int         NUM_VEC   = 256,
   parameter int         LAT       = 1,
   parameter int         ERR_W     = 8,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pin_loopback_checker_if.slave  bus
);

   // An all-zero seed would lock the LFSR, so it is swapped for 8'h01.
   localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

   localparam int CNT_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int DRN_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(NUM_VEC - 1);
   localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [7:0]       r_stim;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [DRN_W-1:0] r_drain_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err_cnt;
   logic [7:0]       r_first_err;

   // Check pipe: stage 0 is loaded on the launch edge, stage LAT-1 is the
   // entry compared against resp_in on the following edge.
   logic             r_pipe_vld  [LAT];
   logic [7:0]       r_pipe_exp  [LAT];
   logic [7:0]       r_pipe_vec  [LAT];
   logic [7:0]       r_pipe_mask [LAT];

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic             w_lfsr_fb;
   logic [7:0]       w_lfsr_next;
   logic             w_launch;
   logic [7:0]       w_exp_in;
   logic [7:0]       w_mask_in;
   logic             w_out_vld;
   logic             w_mismatch;
   logic             w_err_sat;
   logic [ERR_W-1:0] w_err_next;
   logic [7:0]       w_first_next;
   logic             w_start_ok;

   // Fibonacci x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3, shifted in at bit 0.
   assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_lfsr_next = {r_lfsr[6:0], w_lfsr_fb};

   assign w_launch = (r_state == S_DRIVE);
   assign w_exp_in = {r_lfsr[7:4], ~r_lfsr[3:0]};

`ifdef CHECK_MASK_EN
   assign w_mask_in = bus.check_mask;
`else
   assign w_mask_in = 8'hFF;
`endif

   assign w_out_vld  = r_pipe_vld[LAT-1];
   assign w_mismatch = w_out_vld &&
                       (((bus.resp_in ^ r_pipe_exp[LAT-1]) & r_pipe_mask[LAT-1]) != 8'h00);

   assign w_err_sat  = &r_err_cnt;
   assign w_err_next = (w_mismatch && !w_err_sat) ? (r_err_cnt + ERR_W'(1)) : r_err_cnt;

   // The count saturates rather than wraps, so a zero count reliably means
   // no mismatch has been recorded yet in this run.
   assign w_first_next = (w_mismatch && (r_err_cnt == '0)) ? r_pipe_vec[LAT-1] : r_first_err;

   assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // ------------------------------------------------------------------------
   // Sequential logic: FSM, LFSR, pipe and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_lfsr      <= SEED;
         r_stim      <= 8'h00;
         r_vec_cnt   <= '0;
         r_drain_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= 8'h00;
         for (int i = 0; i < LAT; i++) begin
            r_pipe_vld[i]  <= 1'b0;
            r_pipe_exp[i]  <= 8'h00;
            r_pipe_vec[i]  <= 8'h00;
            r_pipe_mask[i] <= 8'h00;
         end
      end else if (bus.ena) begin
         // Pipe advances every enabled edge; bubbles carry valid=0.
         r_pipe_vld[0]  <= w_launch;
         r_pipe_exp[0]  <= w_exp_in;
         r_pipe_vec[0]  <= r_lfsr;
         r_pipe_mask[0] <= w_mask_in;
         for (int i = 1; i < LAT; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_exp[i]  <= r_pipe_exp[i-1];
            r_pipe_vec[i]  <= r_pipe_vec[i-1];
            r_pipe_mask[i] <= r_pipe_mask[i-1];
         end

         // Only valid pipe entries can raise w_mismatch, so outside
         // DRIVE/DRAIN these hold their values.
         r_err_cnt   <= w_err_next;
         r_first_err <= w_first_next;

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  // Later assignments override the generic result update.
                  r_state     <= S_DRIVE;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_err_cnt   <= '0;
                  r_first_err <= 8'h00;
                  r_lfsr      <= SEED;
                  r_vec_cnt   <= '0;
               end
            end

            S_DRIVE: begin
               r_stim <= r_lfsr;
               r_lfsr <= w_lfsr_next;
               if (r_vec_cnt == LAST_VEC) begin
                  r_vec_cnt   <= '0;
                  r_drain_cnt <= '0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_vec_cnt <= r_vec_cnt + CNT_W'(1);
               end
            end

            S_DRAIN: begin
               // stim_out holds the last vector while in-flight checks land.
               if (r_drain_cnt == LAST_DRAIN) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  // Include the check completing on this very edge.
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRN_W'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all registered)
   // ------------------------------------------------------------------------
   assign bus.stim_out      = r_stim;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.pass          = r_pass;
   assign bus.err_count     = r_err_cnt;
   assign bus.first_err_vec = r_first_err;
   assign bus.dbg_state     = r_state;

endmodule
